pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_pkg.sv | 15 +
 rtl/pipe_track.sv | 56 +++++
 rtl/pipe_hazard_ctrl.sv | 110 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
// Tracker entries carry rd at a fixed maximum width so any legal REGW fits.
package pipe_pkg;
   localparam int DEF_NSTAGE = 3;
   localparam int DEF_REGW   = 5;
   localparam int MAX_REGW   = 16;
   localparam int FWD_RF     = 0;

   typedef struct packed {
      logic                valid;
      logic [MAX_REGW-1:0] rd;
      logic                we;
      logic                is_load;
   } trk_entry_t;
endpackage

// File: rtl/pipe_track.sv
// Shift tracker mirroring post-decode stages 1..NSTAGE (1 = youngest).
// Advances only when the pipe advances; stage 1 takes a bubble unless load is set.
module pipe_track
   import pipe_pkg::*;
#(
   parameter int NSTAGE = DEF_NSTAGE,
   parameter int REGW   = DEF_REGW
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   advance,
   input  logic                   load,
   input  logic [REGW-1:0]        rd,
   input  logic                   we,
   input  logic                   is_load,
   output trk_entry_t [NSTAGE:1]  ent
);

   trk_entry_t ent_reg [1:NSTAGE];
   trk_entry_t new_entry;

   always_comb begin
      new_entry = '0;
      if (load) begin
         new_entry.valid   = 1'b1;
         new_entry.rd      = MAX_REGW'(rd);
         new_entry.we      = we;
         new_entry.is_load = is_load;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ent_reg[1] <= '0;
      end else if (advance) begin
         ent_reg[1] <= new_entry;
      end
   end

   genvar gi;
   generate
      for (gi = 2; gi <= NSTAGE; gi++) begin : g_shift
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               ent_reg[gi] <= '0;
            end else if (advance) begin
               ent_reg[gi] <= ent_reg[gi-1];
            end
         end
      end
      for (gi = 1; gi <= NSTAGE; gi++) begin : g_out
         assign ent[gi] = ent_reg[gi];
      end
   endgenerate

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Decode-stage hazard controller: RAW detection, stall/flush and forward selects.
// Define FORWARD_EN to enable forwarding; otherwise a full RAW interlock is built.
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int NSTAGE = DEF_NSTAGE,
   parameter int REGW   = DEF_REGW,
   parameter int SELW   = $clog2(NSTAGE+1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            dc_valid,
   input  logic [REGW-1:0] dc_rs1,
   input  logic [REGW-1:0] dc_rs2,
   input  logic            dc_use_rs1,
   input  logic            dc_use_rs2,
   input  logic [REGW-1:0] dc_rd,
   input  logic            dc_we,
   input  logic            dc_is_load,
   input  logic            ex_taken,
   input  logic            mem_busy,
   output logic            stall_fe,
   output logic            stall_dc,
   output logic            flush_fe,
   output logic            flush_dc,
   output logic [SELW-1:0] fwd_a_sel,
   output logic [SELW-1:0] fwd_b_sel,
   output logic [31:0]     stall_cnt
);

   trk_entry_t [NSTAGE:1] ent;
   logic [NSTAGE:1] match_a;
   logic [NSTAGE:1] match_b;
   logic [NSTAGE:1] load_bits;
   logic            unused_load;
   logic            raw_stall;
   logic            flush;
   logic            hazard;
   logic            track_load;
   logic [SELW-1:0] sel_a;
   logic [SELW-1:0] sel_b;
   logic [31:0]     cnt_reg;

   pipe_track #(
      .NSTAGE (NSTAGE),
      .REGW   (REGW)
   ) u_track (
      .clk     (clk),
      .rst     (rst),
      .advance (!mem_busy),
      .load    (track_load),
      .rd      (dc_rd),
      .we      (dc_we),
      .is_load (dc_is_load),
      .ent     (ent)
   );

   genvar gi;
   generate
      for (gi = 1; gi <= NSTAGE; gi++) begin : g_match
         assign match_a[gi] = ent[gi].valid && ent[gi].we && dc_use_rs1 &&
                              (dc_rs1 != '0) && (ent[gi].rd == MAX_REGW'(dc_rs1));
         assign match_b[gi] = ent[gi].valid && ent[gi].we && dc_use_rs2 &&
                              (dc_rs2 != '0) && (ent[gi].rd == MAX_REGW'(dc_rs2));
         assign load_bits[gi] = ent[gi].is_load;
      end
   endgenerate

   // Only stage 1's load flag matters with forwarding, none without it.
   assign unused_load = ^load_bits;

`ifdef FORWARD_EN
   // Lowest matching stage is the youngest producer.
   function automatic logic [SELW-1:0] youngest(input logic [NSTAGE:1] m);
      youngest = SELW'(FWD_RF);
      for (int k = NSTAGE; k >= 1; k--) begin
         if (m[k]) youngest = SELW'(k);
      end
   endfunction

   assign sel_a     = youngest(match_a);
   assign sel_b     = youngest(match_b);
   assign raw_stall = dc_valid && ent[1].is_load && (match_a[1] || match_b[1]);
`else
   assign sel_a     = SELW'(FWD_RF);
   assign sel_b     = SELW'(FWD_RF);
   assign raw_stall = dc_valid && ((|match_a) || (|match_b));
`endif

   assign flush      = ex_taken && !mem_busy;
   assign hazard     = raw_stall && !flush;
   assign track_load = dc_valid && !hazard && !flush;

   assign stall_fe  = !rst && (hazard || mem_busy);
   assign stall_dc  = stall_fe;
   assign flush_fe  = !rst && flush;
   assign flush_dc  = flush_fe;
   assign fwd_a_sel = rst ? '0 : sel_a;
   assign fwd_b_sel = rst ? '0 : sel_b;
   assign stall_cnt = cnt_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_reg <= '0;
      end else if (hazard && !mem_busy && (cnt_reg != 32'hFFFF_FFFF)) begin
         cnt_reg <= cnt_reg + 32'd1;
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a per-cycle instruction-history model.
// Expectations adapt to FORWARD_EN; literal checks pin each scenario's outcome.
module tb_pipe_hazard_ctrl;
   localparam int NS = 3;
   localparam int RW = 5;
   localparam int SW = 2;
`ifdef FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic          clk, rst;
   logic          dc_valid, dc_use_rs1, dc_use_rs2, dc_we, dc_is_load;
   logic [RW-1:0] dc_rs1, dc_rs2, dc_rd;
   logic          ex_taken, mem_busy;
   logic          stall_fe, stall_dc, flush_fe, flush_dc;
   logic [SW-1:0] fwd_a_sel, fwd_b_sel;
   logic [31:0]   stall_cnt;

   int checks = 0;
   int failures = 0;

   // History of instructions that left decode: slot k = stage k.
   bit          mv [1:NS];
   int          mrd [1:NS];
   bit          mwe [1:NS];
   bit          mld [1:NS];
   logic [31:0] mcnt;
   bit          e_stall, e_flush, e_haz;
   int          e_sela, e_selb;

   // Outputs captured by the last cycle() call, before its clock edge.
   bit o_stall, o_flush_fe, o_flush_dc;
   int o_sela, o_selb;

   pipe_hazard_ctrl #(.NSTAGE(NS), .REGW(RW)) dut (
      .clk(clk), .rst(rst),
      .dc_valid(dc_valid), .dc_rs1(dc_rs1), .dc_rs2(dc_rs2),
      .dc_use_rs1(dc_use_rs1), .dc_use_rs2(dc_use_rs2),
      .dc_rd(dc_rd), .dc_we(dc_we), .dc_is_load(dc_is_load),
      .ex_taken(ex_taken), .mem_busy(mem_busy),
      .stall_fe(stall_fe), .stall_dc(stall_dc),
      .flush_fe(flush_fe), .flush_dc(flush_dc),
      .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
      .stall_cnt(stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   function automatic int youngest(input int src, input bit used);
      for (int k = 1; k <= NS; k++)
         if (mv[k] && mwe[k] && mrd[k] == src && src != 0 && used) return k;
      return 0;
   endfunction

   task automatic model_reset();
      for (int k = 1; k <= NS; k++) begin
         mv[k] = 0; mrd[k] = 0; mwe[k] = 0; mld[k] = 0;
      end
      mcnt = 0;
   endtask

   task automatic model_eval();
      int  ya, yb;
      bit  raw;
      ya = youngest(int'(dc_rs1), dc_use_rs1);
      yb = youngest(int'(dc_rs2), dc_use_rs2);
      if (FWD) begin
         raw = dc_valid && mld[1] && (ya == 1 || yb == 1);
         e_sela = ya; e_selb = yb;
      end else begin
         raw = dc_valid && (ya != 0 || yb != 0);
         e_sela = 0; e_selb = 0;
      end
      e_flush = ex_taken && !mem_busy;
      e_haz   = raw && !e_flush;
      e_stall = e_haz || mem_busy;
      if (rst) begin
         e_flush = 0; e_stall = 0; e_sela = 0; e_selb = 0;
      end
   endtask

   task automatic model_update();
      if (!mem_busy) begin
         if (e_haz && mcnt != 32'hFFFF_FFFF) mcnt = mcnt + 1;
         for (int k = NS; k >= 2; k--) begin
            mv[k] = mv[k-1]; mrd[k] = mrd[k-1]; mwe[k] = mwe[k-1]; mld[k] = mld[k-1];
         end
         mv[1]  = dc_valid && !e_haz && !e_flush;
         mrd[1] = int'(dc_rd); mwe[1] = dc_we; mld[1] = dc_is_load;
      end
   endtask

   task automatic compare_all();
      chk("stall_fe", stall_fe, e_stall);
      chk("stall_dc", stall_dc, e_stall);
      chk("flush_fe", flush_fe, e_flush);
      chk("flush_dc", flush_dc, e_flush);
      chk("fwd_a_sel", fwd_a_sel, e_sela);
      chk("fwd_b_sel", fwd_b_sel, e_selb);
      chk("stall_cnt", stall_cnt, mcnt);
   endtask

   // Inputs are set at the falling edge; this checks, then advances one clock.
   task automatic cycle();
      #1;
      model_eval();
      compare_all();
      o_stall = stall_dc; o_flush_fe = flush_fe; o_flush_dc = flush_dc;
      o_sela = fwd_a_sel; o_selb = fwd_b_sel;
      $display("cyc t=%0t v=%0d rs1=%0d rs2=%0d rd=%0d ld=%0d tk=%0d busy=%0d stall=%0d flush=%0d fa=%0d fb=%0d cnt=%0d",
               $time, dc_valid, dc_rs1, dc_rs2, dc_rd, dc_is_load, ex_taken, mem_busy,
               stall_dc, flush_dc, fwd_a_sel, fwd_b_sel, stall_cnt);
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic drive(input bit v, input int rs1, input int rs2, input int rd, input bit ld);
      dc_valid = v; dc_rs1 = RW'(rs1); dc_rs2 = RW'(rs2); dc_rd = RW'(rd);
      dc_use_rs1 = v; dc_use_rs2 = v; dc_we = v; dc_is_load = ld;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0);
      ex_taken = 0; mem_busy = 0;
   endtask

   task automatic issue(input int rs1, input int rs2, input int rd, input bit ld);
      drive(1, rs1, rs2, rd, ld);
      cycle();
      idle();
   endtask

   task automatic drain();
      idle();
      repeat (NS + 1) cycle();
   endtask

   task automatic do_reset();
      idle();
      rst = 1;
      #1;
      model_reset();
      model_eval();
      compare_all();
      chk("rst_cnt_zero", stall_cnt, 0);
      @(posedge clk);
      @(negedge clk);
      rst = 0;
   endtask

   // Holds the current decode instruction until it is no longer stalled.
   task automatic run_reader(output int n, output int sa, output int sb);
      n = 0; sa = -1; sb = -1;
      for (int i = 0; i < 10; i++) begin
         cycle();
         if (!o_stall) begin
            sa = o_sela; sb = o_selb;
            break;
         end
         n++;
      end
      if (sa < 0) chk("reader_timeout", n, -1);
      idle();
   endtask

   initial begin
      int n, sa, sb;
      rst = 1;
      idle();
      @(negedge clk);
      do_reset();

      // add x5 ; add x6,x5,x1
      issue(1, 2, 5, 0);
      drive(1, 5, 1, 6, 0);
      run_reader(n, sa, sb);
      chk("s1_stalls", n, FWD ? 0 : 3);
      chk("s1_fwd_a", sa, FWD ? 1 : 0);
      chk("s1_fwd_b", sb, 0);
      chk("s1_cnt", stall_cnt, FWD ? 0 : 3);
      drain();

      // lw x5 ; add x7,x5,x5
      do_reset();
      issue(1, 2, 5, 1);
      drive(1, 5, 5, 7, 0);
      run_reader(n, sa, sb);
      chk("s2_stalls", n, FWD ? 1 : 3);
      chk("s2_fwd_a", sa, FWD ? 2 : 0);
      chk("s2_fwd_b", sb, FWD ? 2 : 0);
      chk("s2_cnt", stall_cnt, FWD ? 1 : 3);
      drain();

      // x3 written in stages 1 and 3, then reader of x3
      do_reset();
      issue(1, 2, 3, 0);
      issue(1, 2, 9, 0);
      issue(1, 2, 3, 0);
      drive(1, 3, 3, 4, 0);
      run_reader(n, sa, sb);
      chk("s3_stalls", n, FWD ? 0 : 3);
      chk("s3_fwd_a", sa, FWD ? 1 : 0);
      chk("s3_fwd_b", sb, FWD ? 1 : 0);
      drain();
      // every stage writing x0, reader of x0
      issue(1, 2, 0, 0);
      issue(1, 2, 0, 0);
      issue(1, 2, 0, 0);
      drive(1, 0, 0, 8, 0);
      run_reader(n, sa, sb);
      chk("s3_x0_stalls", n, 0);
      chk("s3_x0_fwd_a", sa, 0);
      chk("s3_x0_fwd_b", sb, 0);
      drain();

      // taken branch in the same cycle as a load-use match
      do_reset();
      issue(1, 2, 5, 1);
      drive(1, 5, 2, 7, 0);
      ex_taken = 1;
      cycle();
      chk("s4_flush_fe", o_flush_fe, 1);
      chk("s4_flush_dc", o_flush_dc, 1);
      chk("s4_stall", o_stall, 0);
      ex_taken = 0;
      drive(1, 7, 5, 8, 0);
      cycle();
      chk("s4_next_stall", o_stall, FWD ? 0 : 1);
      chk("s4_next_fwd_a", o_sela, 0);
      chk("s4_next_fwd_b", o_selb, FWD ? 2 : 0);
      chk("s4_cnt", stall_cnt, FWD ? 0 : 1);
      drain();

      // freeze with a load-use pending, then reset mid-freeze
      do_reset();
      issue(1, 2, 5, 1);
      drive(1, 5, 5, 7, 0);
      run_reader(n, sa, sb);
      issue(1, 2, 5, 1);
      drive(1, 5, 6, 8, 0);
      mem_busy = 1;
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("s5_busy_stall", o_stall, 1);
         chk("s5_busy_cnt", stall_cnt, FWD ? 1 : 3);
      end
      #2;
      rst = 1;
      #1;
      model_reset();
      model_eval();
      chk("s5_rst_stall_fe", stall_fe, 0);
      chk("s5_rst_stall_dc", stall_dc, 0);
      chk("s5_rst_flush", flush_fe || flush_dc, 0);
      chk("s5_rst_fwd", fwd_a_sel | fwd_b_sel, 0);
      chk("s5_rst_cnt", stall_cnt, 0);
      @(posedge clk);
      @(negedge clk);
      rst = 0;
      mem_busy = 0;
      cycle();
      chk("s5_after_rst_stall", o_stall, 0);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
